// File: rtl/grf_wport_arbiter.sv
// Arbitrates the single GRF write port between the WB stage and the MDU, tracks MDU busy registers,
// and forces an MDU slot on starvation. Optional trace output under `GRF_ARB_TRACE_EN.
module grf_wport_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned CNT_W    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_we,
   input  logic [4:0]  wb_a3,
   input  logic [31:0] wb_wd,
   input  logic [31:0] wb_pc,
   input  logic        mdu_valid,
   output logic        mdu_ready,
   input  logic [4:0]  mdu_a3,
   input  logic [31:0] mdu_wd,
   input  logic [31:0] mdu_pc,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   output logic        rs_busy,
   output logic        rt_busy,
   output logic        stall_req,
   output logic        grf_we,
   output logic [4:0]  grf_a3,
   output logic [31:0] grf_wd,
   output logic [31:0] grf_pc
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_stall_req;
   logic [31:1]       r_busy;
   logic              r_grf_we;
   logic [4:0]        r_grf_a3;
   logic [31:0]       r_grf_wd;
   logic [31:0]       r_grf_pc;

   logic              w_xfer;
   logic [31:0]       w_busy_full;

   // Pipeline always wins the port; the MDU only moves when WB is silent.
   assign mdu_ready   = !wb_we;
   assign w_xfer      = mdu_valid && !wb_we;
   assign w_busy_full = {r_busy, 1'b0};
   assign rs_busy     = w_busy_full[rs_addr];
   assign rt_busy     = w_busy_full[rt_addr];

   assign stall_req   = r_stall_req;
   assign grf_we      = r_grf_we;
   assign grf_a3      = r_grf_a3;
   assign grf_wd      = r_grf_wd;
   assign grf_pc      = r_grf_pc;

   // Registered write port; $0 targets complete the grant but never assert WE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_grf_we <= 1'b0;
         r_grf_a3 <= 5'd0;
         r_grf_wd <= 32'd0;
         r_grf_pc <= 32'd0;
      end else if (wb_we) begin
         r_grf_we <= (wb_a3 != 5'd0);
         r_grf_a3 <= wb_a3;
         r_grf_wd <= wb_wd;
         r_grf_pc <= wb_pc;
      end else if (w_xfer) begin
         r_grf_we <= (mdu_a3 != 5'd0);
         r_grf_a3 <= mdu_a3;
         r_grf_wd <= mdu_wd;
         r_grf_pc <= mdu_pc;
      end else begin
         r_grf_we <= 1'b0;
      end
   end

   // Busy scoreboard: a same-cycle issue to a register overrides its completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy <= '0;
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (iss_valid && (iss_rd == 5'(i)))
               r_busy[i] <= 1'b1;
            else if (w_xfer && (mdu_a3 == 5'(i)))
               r_busy[i] <= 1'b0;
         end
      end
   end

   // Starvation tracker: after MAX_WAIT blocked cycles, request one pipeline freeze.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_stall_req <= 1'b0;
      end else begin
         r_stall_req <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (mdu_valid && wb_we) begin
                  r_state <= S_WAIT;
                  r_cnt   <= CNT_W'(1);
               end
            end
            S_WAIT: begin
               if (w_xfer || !mdu_valid) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_W'(MAX_WAIT)) begin
                  r_state     <= S_FORCE;
                  r_stall_req <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_FORCE: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

`ifdef GRF_ARB_TRACE_EN
   always @(posedge clk) begin
      if (!reset && r_grf_we)
         $display("@%h: $%0d <= %h", r_grf_pc, r_grf_a3, r_grf_wd);
      if (!reset && (r_state == S_FORCE) && wb_we)
         $display("ERROR: grf_wport_arbiter wb_we asserted during forced MDU slot (pc=%h)", wb_pc);
   end
`else
`endif

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed self-checking bench for grf_wport_arbiter (MAX_WAIT=4).
module tb_grf_wport_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_we;
   logic [4:0]  wb_a3;
   logic [31:0] wb_wd;
   logic [31:0] wb_pc;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_a3;
   logic [31:0] mdu_wd;
   logic [31:0] mdu_pc;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic        rs_busy;
   logic        rt_busy;
   logic        stall_req;
   logic        grf_we;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd;
   logic [31:0] grf_pc;

   int checks   = 0;
   int failures = 0;

   grf_wport_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
      .clk(clk), .reset(reset),
      .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd), .wb_pc(wb_pc),
      .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_a3(mdu_a3),
      .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
      .stall_req(stall_req),
      .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; wb_we = 1'b0; wb_a3 = '0; wb_wd = '0; wb_pc = '0;
      mdu_valid = 1'b0; mdu_a3 = '0; mdu_wd = '0; mdu_pc = '0;
      iss_valid = 1'b0; iss_rd = '0; rs_addr = 5'd1; rt_addr = 5'd2;
      tick(); tick();
      checks++; if ({grf_we, grf_a3, grf_wd, grf_pc} !== 70'd0) begin failures++; $display("FAIL reset_grf got we=%b a3=%0d wd=%h pc=%h exp all 0", grf_we, grf_a3, grf_wd, grf_pc); end
      checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got %b exp 0", stall_req); end
      checks++; if ({rs_busy, rt_busy, mdu_ready} !== 3'b001) begin failures++; $display("FAIL reset_busy_ready got %b exp 001", {rs_busy, rt_busy, mdu_ready}); end
      #3 reset = 1'b0;
      tick();
   endtask

   task automatic test_pipeline();
      wb_we = 1'b1; wb_a3 = 5'd5; wb_wd = 32'h1234_5678; wb_pc = 32'h0000_3000; mdu_valid = 1'b1; mdu_a3 = 5'd6;
      #1;
      checks++; if (mdu_ready !== 1'b0) begin failures++; $display("FAIL pipe_ready got %b exp 0", mdu_ready); end
      mdu_valid = 1'b0;
      tick();
      wb_we = 1'b0; wb_wd = 32'hFFFF_FFFF;
      checks++; if ({grf_we, grf_a3, grf_wd, grf_pc} !== {1'b1, 5'd5, 32'h1234_5678, 32'h0000_3000}) begin failures++; $display("FAIL pipe_write got we=%b a3=%0d wd=%h pc=%h exp 1/5/12345678/00003000", grf_we, grf_a3, grf_wd, grf_pc); end
      tick();
      checks++; if ({grf_we, grf_a3, grf_wd} !== {1'b0, 5'd5, 32'h1234_5678}) begin failures++; $display("FAIL pipe_hold got we=%b a3=%0d wd=%h exp 0/5/12345678", grf_we, grf_a3, grf_wd); end
   endtask

   task automatic test_mdu();
      iss_valid = 1'b1; iss_rd = 5'd8; rs_addr = 5'd8;
      tick();
      iss_valid = 1'b0;
      checks++; if (rs_busy !== 1'b1) begin failures++; $display("FAIL mdu_busy_set got %b exp 1", rs_busy); end
      mdu_valid = 1'b1; mdu_a3 = 5'd8; mdu_wd = 32'hDEAD_0000; mdu_pc = 32'h0000_4000;
      #1;
      checks++; if ({mdu_ready, rs_busy} !== 2'b11) begin failures++; $display("FAIL mdu_pre_xfer got ready/busy=%b exp 11", {mdu_ready, rs_busy}); end
      tick();
      mdu_valid = 1'b0;
      checks++; if ({grf_we, grf_a3, grf_wd, grf_pc} !== {1'b1, 5'd8, 32'hDEAD_0000, 32'h0000_4000}) begin failures++; $display("FAIL mdu_write got we=%b a3=%0d wd=%h pc=%h exp 1/8/dead0000/00004000", grf_we, grf_a3, grf_wd, grf_pc); end
      checks++; if (rs_busy !== 1'b0) begin failures++; $display("FAIL mdu_busy_clr got %b exp 0", rs_busy); end
   endtask

   task automatic test_contention();
      wb_we = 1'b1; wb_a3 = 5'd1; wb_wd = 32'h0000_0011; wb_pc = 32'h0000_5000;
      mdu_valid = 1'b1; mdu_a3 = 5'd10; mdu_wd = 32'hCAFE_0001; mdu_pc = 32'h0000_6000;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if ({stall_req, grf_we, grf_a3} !== {1'b0, 1'b1, 5'd1}) begin failures++; $display("FAIL cont_wait%0d got stall=%b we=%b a3=%0d exp 0/1/1", k, stall_req, grf_we, grf_a3); end
      end
      tick();
      checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL cont_stall got %b exp 1", stall_req); end
      wb_we = 1'b0;
      #1;
      checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL cont_ready got %b exp 1", mdu_ready); end
      tick();
      mdu_valid = 1'b0;
      checks++; if ({stall_req, grf_we, grf_a3, grf_wd, grf_pc} !== {1'b0, 1'b1, 5'd10, 32'hCAFE_0001, 32'h0000_6000}) begin failures++; $display("FAIL cont_grant got stall=%b we=%b a3=%0d wd=%h pc=%h exp 0/1/10/cafe0001/00006000", stall_req, grf_we, grf_a3, grf_wd, grf_pc); end
      tick();
   endtask

   task automatic test_set_clear();
      iss_valid = 1'b1; iss_rd = 5'd9; rt_addr = 5'd9;
      tick();
      mdu_valid = 1'b1; mdu_a3 = 5'd9; mdu_wd = 32'h0000_0099;
      tick();
      iss_valid = 1'b0;
      checks++; if ({rt_busy, grf_we, grf_a3} !== {1'b1, 1'b1, 5'd9}) begin failures++; $display("FAIL setclr_same got busy=%b we=%b a3=%0d exp 1/1/9", rt_busy, grf_we, grf_a3); end
      tick();
      mdu_valid = 1'b0;
      checks++; if (rt_busy !== 1'b0) begin failures++; $display("FAIL setclr_after got %b exp 0", rt_busy); end
   endtask

   task automatic test_zero();
      wb_we = 1'b1; wb_a3 = 5'd0; wb_wd = 32'h0000_0055; iss_valid = 1'b1; iss_rd = 5'd0; rs_addr = 5'd0;
      tick();
      wb_we = 1'b0; iss_valid = 1'b0;
      checks++; if ({grf_we, rs_busy} !== 2'b00) begin failures++; $display("FAIL zero_wb got we/busy=%b exp 00", {grf_we, rs_busy}); end
      mdu_valid = 1'b1; mdu_a3 = 5'd0; mdu_wd = 32'h0000_0077;
      #1;
      checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got %b exp 1", mdu_ready); end
      tick();
      mdu_valid = 1'b0;
      checks++; if ({grf_we, grf_wd} !== {1'b0, 32'h0000_0077}) begin failures++; $display("FAIL zero_mdu got we=%b wd=%h exp 0/00000077", grf_we, grf_wd); end
   endtask

   task automatic test_async_reset();
      iss_valid = 1'b1; iss_rd = 5'd3; rs_addr = 5'd3;
      tick();
      iss_valid = 1'b0;
      wb_we = 1'b1; wb_a3 = 5'd7; wb_wd = 32'h0000_0707; wb_pc = 32'h0000_7000; mdu_valid = 1'b1; mdu_a3 = 5'd12;
      tick(); tick();
      checks++; if ({rs_busy, grf_we, stall_req} !== 3'b110) begin failures++; $display("FAIL arst_pre got busy/we/stall=%b exp 110", {rs_busy, grf_we, stall_req}); end
      #2 reset = 1'b1;
      #1;
      checks++; if ({grf_we, grf_a3, grf_wd, grf_pc, stall_req, rs_busy} !== 72'd0) begin failures++; $display("FAIL arst_now got we=%b a3=%0d wd=%h pc=%h stall=%b busy=%b exp all 0", grf_we, grf_a3, grf_wd, grf_pc, stall_req, rs_busy); end
      #2 reset = 1'b0;
      // Counter must restart from scratch: four quiet edges, stall on the fifth.
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL arst_wait%0d got %b exp 0", k, stall_req); end
      end
      tick();
      checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL arst_stall got %b exp 1", stall_req); end
      // Pipeline ignores the freeze: it still owns the port and the slot is lost.
      wb_a3 = 5'd13;
      tick();
      checks++; if ({stall_req, grf_we, grf_a3} !== {1'b0, 1'b1, 5'd13}) begin failures++; $display("FAIL viol_wb got stall=%b we=%b a3=%0d exp 0/1/13", stall_req, grf_we, grf_a3); end
      wb_we = 1'b0; mdu_valid = 1'b0;
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_pipeline();
      test_mdu();
      test_contention();
      test_set_clear();
      test_zero();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
